// File: rtl/dct_block_sequencer.sv
// Front-end sequencer for the 8x8 DCT core: gathers 64 pixels into dct_A, waits out the
// core latency, then drains eight coefficient rows. Optional macro: DCT_SEQ_LEVEL_SHIFT_EN.
module dct_block_sequencer #(
    parameter int PIX_W       = 8,
    parameter int COEF_ROW_W  = 104,
    parameter int DCT_LATENCY = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PIX_W-1:0]        in_pixel,
    output logic [64*PIX_W-1:0]     dct_A,
    output logic                    dct_start,
    output logic [2:0]              dct_row_sel,
    input  logic [COEF_ROW_W-1:0]   dct_D,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COEF_ROW_W-1:0]   out_row,
    output logic [2:0]              out_row_idx,
    output logic                    out_last,
    output logic                    busy,
    output logic [15:0]             block_count
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] LATENCY = 8'(DCT_LATENCY);

    state_t      state_reg, state_next;
    logic [5:0]  pix_cnt_reg, pix_cnt_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic [2:0]  row_cnt_reg, row_cnt_next;
    logic        start_reg, start_next;
    logic [15:0] block_count_reg, block_count_next;
    logic        load_fire;
    logic [PIX_W-1:0] store_pixel;

`ifdef DCT_SEQ_LEVEL_SHIFT_EN
    // Flipping the MSB is the same as subtracting 128 in 8-bit two's complement.
    localparam logic [PIX_W-1:0] SHIFT_MASK = {1'b1, {(PIX_W-1){1'b0}}};
    assign store_pixel = in_pixel ^ SHIFT_MASK;
`else
    assign store_pixel = in_pixel;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= LOAD;
            pix_cnt_reg     <= '0;
            wait_cnt_reg    <= '0;
            row_cnt_reg     <= '0;
            start_reg       <= 1'b0;
            block_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            pix_cnt_reg     <= pix_cnt_next;
            wait_cnt_reg    <= wait_cnt_next;
            row_cnt_reg     <= row_cnt_next;
            start_reg       <= start_next;
            block_count_reg <= block_count_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pix_cnt_next     = pix_cnt_reg;
        wait_cnt_next    = wait_cnt_reg;
        row_cnt_next     = row_cnt_reg;
        start_next       = 1'b0;
        block_count_next = block_count_reg;
        load_fire        = 1'b0;
        case (state_reg)
            LOAD: begin
                if (in_valid) begin
                    load_fire    = 1'b1;
                    pix_cnt_next = pix_cnt_reg + 6'd1;
                    if (pix_cnt_reg == 6'd63) begin
                        state_next    = RUN;
                        start_next    = 1'b1;
                        wait_cnt_next = LATENCY;
                    end
                end
            end
            RUN: begin
                // Counter reaches zero DCT_LATENCY edges after the start pulse is raised.
                if (wait_cnt_reg == 8'd0) begin
                    state_next   = DRAIN;
                    row_cnt_next = 3'd0;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 8'd1;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    row_cnt_next = row_cnt_reg + 3'd1;
                    if (row_cnt_reg == 3'd7) begin
                        state_next       = LOAD;
                        block_count_next = block_count_reg + 16'd1;
                    end
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // One register per pixel slot; untouched slots keep the previous block's value.
    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_slot
            logic [PIX_W-1:0] slot_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    slot_reg <= '0;
                end else if (load_fire && (pix_cnt_reg == 6'(gi))) begin
                    slot_reg <= store_pixel;
                end
            end
            assign dct_A[(63-gi)*PIX_W +: PIX_W] = slot_reg;
        end
    endgenerate

    assign in_ready    = (state_reg == LOAD);
    assign dct_start   = start_reg;
    assign dct_row_sel = row_cnt_reg;
    assign out_valid   = (state_reg == DRAIN);
    assign out_row     = dct_D;
    assign out_row_idx = row_cnt_reg;
    assign out_last    = (state_reg == DRAIN) && (row_cnt_reg == 3'd7);
    assign busy        = (state_reg != LOAD) || (pix_cnt_reg != 6'd0);
    assign block_count = block_count_reg;

endmodule

// File: doc/dct_block_sequencer.md
# dct_block_sequencer

Front-end controller for the 8x8 DCT datapath (`dct_final`). It accepts pixels as a serial valid/ready stream, assembles one 64-pixel block into the core's 512-bit `A` bus, and holds that bus stable for the core's fixed latency. It then drains the eight 104-bit coefficient rows of `D` to a downstream valid/ready consumer. One block is in flight at a time; the sequencer sits between the image-tile fetcher and the entropy/quantiser stage.

## Interface

Parameters:
- `PIX_W`, 8, pixel width.
- `COEF_ROW_W`, 104, width of one coefficient row (8 x 13 bits).
- `DCT_LATENCY`, 16, cycles from `dct_start` until `dct_D` is valid for every row select; legal range 1..255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; all state cleared immediately.
- `in_valid`  in  1  pixel present.
- `in_ready`  out  1  sequencer accepts pixel.
- `in_pixel`  in  PIX_W  pixel, raster order (row-major, pixel 0 first).
- `dct_A`  out  512  block to core; pixel k in bits [511-8k : 504-8k].
- `dct_start`  out  1  one-cycle pulse, block loaded.
- `dct_row_sel`  out  3  row index the core presents on `dct_D`.
- `dct_D`  in  COEF_ROW_W  coefficient row from core (combinational on `dct_row_sel`).
- `out_valid`  out  1  coefficient row present.
- `out_ready`  in  1  consumer accepts row.
- `out_row`  out  COEF_ROW_W  coefficient row.
- `out_row_idx`  out  3  row number of `out_row`.
- `out_last`  out  1  high with row 7.
- `busy`  out  1  state != LOAD, or pixel count != 0.
- `block_count`  out  16  completed blocks, wraps.

## Operation

- States: LOAD, RUN, DRAIN.
- LOAD: `in_ready`=1. On `in_valid&&in_ready`, write the pixel into slot `pix_cnt`; increment 6-bit `pix_cnt`. On accepting pixel 63: `pix_cnt` wraps to 0, go to RUN, and assert `dct_start` for the next cycle.
- RUN: `in_ready`=0. The wait counter is loaded with DCT_LATENCY and decrements each cycle. At 0, go to DRAIN with row counter 0.
- DRAIN: `dct_row_sel`=row counter. `out_row`=`dct_D`, `out_row_idx`=row counter, and `out_valid`=1. The row advances on `out_valid&&out_ready`. Acceptance of row 7 returns the block to LOAD and increments `block_count` (modulo 2^16).
- `dct_A` is written only in LOAD and is held unchanged through RUN and DRAIN. Slots not yet rewritten keep the previous block's data.
- `in_valid` in RUN or DRAIN is ignored; the pixel is not consumed.
- While `out_valid&&!out_ready`, `out_row`, `out_row_idx` and `out_last` remain stable.

## Timing

- Reset values: `in_ready`=1 (after reset), `dct_A`=0, `dct_start`=0, `dct_row_sel`=0, `out_valid`=0, `out_last`=0, `out_row_idx`=0, `busy`=0, `block_count`=0, state=LOAD.
- Load takes 64 accepting cycles minimum. Input gaps (`in_valid`=0) stall `pix_cnt`.
- Edge E accepts pixel 63. `dct_start`=1 during cycle E+1. `out_valid` rises at edge E+1+DCT_LATENCY.
- With `out_ready` held high, the drain takes 8 cycles. First pixel of the next block is accepted no earlier than the cycle after row 7 is accepted. Block throughput is 64+1+DCT_LATENCY+8 cycles minimum.
- If `reset` is asserted mid-LOAD, RUN or DRAIN, the partial block is discarded, outputs return to reset values, and the pending `block_count` increment does not occur.

## Configuration

- `DCT_SEQ_LEVEL_SHIFT_EN`:
  - Defined: each accepted pixel is stored as `in_pixel - 128` (two's complement, 8 bits; i.e. MSB inverted), giving the JPEG level shift, so the core receives signed samples.
  - Undefined: pixels are stored unmodified.

## Test plan

- 64 pixels 0..63, `out_ready`=1, no macro → `dct_A[511:504]`=0 and `dct_A[7:0]`=63. `dct_start` is a single pulse at E+1. `out_valid` rises at E+17. Rows 0..7 are emitted on consecutive cycles, `out_last` is set on row 7, and `block_count`=1.
- Same with `DCT_SEQ_LEVEL_SHIFT_EN` and all pixels 8'd128 → `dct_A`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles during row 3 → row 3 and `out_row_idx`=3 stay stable. Row 4 appears only after the accept.
- `in_valid`=1 throughout RUN/DRAIN with pixel 8'hAA → `in_ready`=0, `dct_A` is unchanged, and the next block's slot 0 receives the first pixel after return to LOAD.
- Assert `reset` during DRAIN row 5 → `out_valid`=0 and `block_count` unchanged. A following full block completes normally.
- Preload `block_count`=16'hFFFF by running 65535 blocks (or via force) → the next completion gives 16'h0000.
